// File: rtl/mem_arb_pkg.sv
// Shared types and the round-robin search helper for mem_rr_arbiter.
package mem_arb_pkg;

  localparam int unsigned MAX_PORTS = 8;

  typedef logic [$clog2(MAX_PORTS)-1:0] port_index_t;

  typedef struct packed {
    logic        found;
    port_index_t index;
  } rr_sel_t;

  // First valid requester at or after rr_ptr, wrapping modulo nports.
  function automatic rr_sel_t rr_select(input logic [MAX_PORTS-1:0] valid,
                                        input port_index_t         rr_ptr,
                                        input int unsigned         nports);
    rr_sel_t     sel;
    int unsigned idx;
    sel = '0;
    for (int unsigned k = 0; k < MAX_PORTS; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= nports) idx = idx - nports;
      if (k < nports && !sel.found && valid[port_index_t'(idx)]) begin
        sel.found = 1'b1;
        sel.index = port_index_t'(idx);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// mem_intf: request/response handshake bundle shared by clients and memory.
interface mem_intf #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
);
  logic                    valid;
  logic                    ready;
  logic                    read_enable;
  logic [DATA_WIDTH/8-1:0] write_enable;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   data;
  logic [ID_WIDTH-1:0]     id;

  modport master (output valid, read_enable, write_enable, addr, data, id, input ready);
  modport slave  (input valid, read_enable, write_enable, addr, data, output ready);
  modport resp_master (output valid, data, input ready);
  modport resp_slave  (input valid, data, output ready);
endinterface

// File: rtl/mem_rr_arbiter_id_fifo.sv
// mem_arb_id_fifo: in-order FIFO of requester indices for outstanding reads.
module mem_arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  port_index_t              push_data,
  input  logic                     pop,
  output port_index_t              pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  port_index_t   mem_q [DEPTH];
  port_index_t   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    count    = count_q;
    pop_data = mem_q[rd_ptr_q];
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_data;
    // Pointers wrap naturally at the power-of-two depth.
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory port among PORTS requesters, with
// in-order read response routing. MEM_RR_ARBITER_STATS_EN adds grant_count.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned PORTS           = 2,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_intf.slave       mem_in [PORTS],
  mem_intf.master      mem_out,
  mem_intf.resp_slave  mem_resp_in,
  mem_intf.resp_master mem_resp_out [PORTS],
  output logic         resp_error
`ifdef MEM_RR_ARBITER_STATS_EN
  , output logic [31:0] grant_count [PORTS]
`endif
);
  localparam int unsigned BW = DATA_WIDTH / 8;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;

  logic [MAX_PORTS-1:0]  req_valid;
  logic [PORTS-1:0]      req_valid_p, req_read, grant_ready;
  logic [PORTS-1:0]      resp_valid_vec, resp_ready_vec;
  logic [BW-1:0]         req_we   [PORTS];
  logic [ADDR_WIDTH-1:0] req_addr [PORTS];
  logic [DATA_WIDTH-1:0] req_data [PORTS];

  rr_sel_t               sel;
  port_index_t           rr_ptr_q, rr_ptr_d;
  logic                  g_read, can_accept, accept, push, pop;
  logic [BW-1:0]         g_we;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_data;

  logic                  out_valid_q, out_valid_d;
  logic                  out_read_q, out_read_d;
  logic [BW-1:0]         out_we_q, out_we_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  resp_error_q, resp_error_d;
  logic                  resp_in_ready;

  port_index_t           fifo_head;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;

  for (genvar i = 0; i < PORTS; i++) begin : g_port
    assign req_valid_p[i]          = mem_in[i].valid;
    assign req_read[i]             = mem_in[i].read_enable;
    assign req_we[i]               = mem_in[i].write_enable;
    assign req_addr[i]             = mem_in[i].addr;
    assign req_data[i]             = mem_in[i].data;
    assign mem_in[i].ready         = grant_ready[i];
    assign mem_resp_out[i].valid   = resp_valid_vec[i];
    assign mem_resp_out[i].data    = mem_resp_in.data;
    assign resp_ready_vec[i]       = mem_resp_out[i].ready;
  end

  always_comb begin : grant
    req_valid              = '0;
    req_valid[PORTS-1:0]   = req_valid_p;
    sel                    = rr_select(req_valid, rr_ptr_q, PORTS);
    g_read = 1'b0;
    g_we   = '0;
    g_addr = '0;
    g_data = '0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      if (sel.index == port_index_t'(k)) begin
        g_read = req_read[k];
        g_we   = req_we[k];
        g_addr = req_addr[k];
        g_data = req_data[k];
      end
    end
    can_accept = !out_valid_q || mem_out.ready;
    // A blocked read holds the grant on its port; a same-cycle pop does not unblock it.
    accept = !rst && sel.found && can_accept &&
             (!g_read || (fifo_count < CW'(MAX_OUTSTANDING)));
    push   = accept && g_read && !fifo_full;
    grant_ready = '0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      if (sel.index == port_index_t'(k)) grant_ready[k] = accept;
    end
  end

  always_comb begin : out_stage
    out_valid_d = out_valid_q;
    out_read_d  = out_read_q;
    out_we_d    = out_we_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_read_d  = g_read;
      out_we_d    = g_read ? '0 : g_we;
      out_addr_d  = g_addr;
      out_data_d  = g_data;
      rr_ptr_d    = (sel.index == port_index_t'(PORTS - 1)) ? '0
                                                             : sel.index + port_index_t'(1);
    end else if (out_valid_q && mem_out.ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin : resp_route
    resp_valid_vec = '0;
    resp_in_ready  = 1'b0;
    pop            = 1'b0;
    resp_error_d   = resp_error_q;
    if (!rst) begin
      if (fifo_empty) begin
        // Unexpected response: swallow it and flag.
        resp_in_ready = 1'b1;
        if (mem_resp_in.valid) resp_error_d = 1'b1;
      end else begin
        for (int unsigned k = 0; k < PORTS; k++) begin
          if (fifo_head == port_index_t'(k)) begin
            resp_valid_vec[k] = mem_resp_in.valid;
            resp_in_ready     = resp_ready_vec[k];
          end
        end
        pop = mem_resp_in.valid && resp_in_ready;
      end
    end
  end

  assign mem_resp_in.ready    = resp_in_ready;
  assign mem_out.valid        = out_valid_q;
  assign mem_out.read_enable  = out_read_q;
  assign mem_out.write_enable = out_we_q;
  assign mem_out.addr         = out_addr_q;
  assign mem_out.data         = out_data_q;
  assign mem_out.id           = '0;
  assign resp_error           = resp_error_q;

  mem_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (sel.index),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_read_q   <= 1'b0;
      out_we_q     <= '0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      rr_ptr_q     <= '0;
      resp_error_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_read_q   <= out_read_d;
      out_we_q     <= out_we_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      rr_ptr_q     <= rr_ptr_d;
      resp_error_q <= resp_error_d;
    end
  end

`ifdef MEM_RR_ARBITER_STATS_EN
  logic [31:0] grant_count_q [PORTS];
  logic [31:0] grant_count_d [PORTS];

  always_comb begin
    grant_count_d = grant_count_q;
    for (int unsigned k = 0; k < PORTS; k++) begin
      if (grant_ready[k]) grant_count_d[k] = grant_count_q[k] + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) grant_count_q <= '{default: '0};
    else     grant_count_q <= grant_count_d;
  end

  assign grant_count = grant_count_q;
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed and randomized checks of mem_rr_arbiter against a queue-based model.
module tb_mem_rr_arbiter;
  localparam int unsigned P  = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned MO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        in_valid [P];
  logic        in_re    [P];
  logic [3:0]  in_we    [P];
  logic [31:0] in_addr  [P];
  logic [31:0] in_data  [P];
  logic        in_ready [P];
  logic        mo_ready, mo_valid, mo_re;
  logic [3:0]  mo_we, mo_id;
  logic [31:0] mo_addr, mo_data;
  logic        ri_valid, ri_ready;
  logic [31:0] ri_data;
  logic        ro_valid [P];
  logic [31:0] ro_data  [P];
  logic        ro_ready [P];
  logic        resp_error;

  mem_intf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_in_if [P] ();
  mem_intf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_out_if ();
  mem_intf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_resp_in_if ();
  mem_intf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_resp_out_if [P] ();

  for (genvar i = 0; i < P; i++) begin : g_tb
    assign mem_in_if[i].valid              = in_valid[i];
    assign mem_in_if[i].read_enable        = in_re[i];
    assign mem_in_if[i].write_enable       = in_we[i];
    assign mem_in_if[i].addr               = in_addr[i];
    assign mem_in_if[i].data               = in_data[i];
    assign mem_in_if[i].id                 = '0;
    assign in_ready[i]                     = mem_in_if[i].ready;
    assign ro_valid[i]                     = mem_resp_out_if[i].valid;
    assign ro_data[i]                      = mem_resp_out_if[i].data;
    assign mem_resp_out_if[i].ready        = ro_ready[i];
    assign mem_resp_out_if[i].read_enable  = 1'b0;
    assign mem_resp_out_if[i].write_enable = '0;
    assign mem_resp_out_if[i].addr         = '0;
    assign mem_resp_out_if[i].id           = '0;
  end

  assign mem_out_if.ready           = mo_ready;
  assign mo_valid                   = mem_out_if.valid;
  assign mo_re                      = mem_out_if.read_enable;
  assign mo_we                      = mem_out_if.write_enable;
  assign mo_addr                    = mem_out_if.addr;
  assign mo_data                    = mem_out_if.data;
  assign mo_id                      = mem_out_if.id;
  assign mem_resp_in_if.valid        = ri_valid;
  assign mem_resp_in_if.data         = ri_data;
  assign ri_ready                    = mem_resp_in_if.ready;
  assign mem_resp_in_if.read_enable  = 1'b0;
  assign mem_resp_in_if.write_enable = '0;
  assign mem_resp_in_if.addr         = '0;
  assign mem_resp_in_if.id           = '0;

`ifdef MEM_RR_ARBITER_STATS_EN
  logic [31:0] grant_count [P];
`endif

  mem_rr_arbiter #(
    .PORTS           (P),
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_in       (mem_in_if),
    .mem_out      (mem_out_if),
    .mem_resp_in  (mem_resp_in_if),
    .mem_resp_out (mem_resp_out_if),
    .resp_error   (resp_error)
`ifdef MEM_RR_ARBITER_STATS_EN
    , .grant_count (grant_count)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: next-priority port, output-stage contents, reads in flight.
  int          rr;
  bit          ov;
  logic        ex_re;
  logic [3:0]  ex_we;
  logic [31:0] ex_addr, ex_data;
  int          q[$];
  bit          err;

  int          obs_grant;
  int          hs_count;
  logic        obs_mo_valid, obs_ri_ready, obs_err;
  logic [31:0] obs_mo_addr, obs_mo_data;
  logic        obs_ro_valid [P];
  logic [31:0] obs_ro_data  [P];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    for (int p = 0; p < P; p++) begin
      in_valid[p] = 1'b0;
      in_re[p]    = 1'b0;
      in_we[p]    = 4'hF;
      in_addr[p]  = '0;
      in_data[p]  = '0;
      ro_ready[p] = 1'b1;
    end
    mo_ready = 1'b1;
    ri_valid = 1'b0;
    ri_data  = '0;
  endtask

  task automatic step();
    int  g;
    bit  found, can, rd, acc, pop, exp_ro;
    @(negedge clk);
    found = 0;
    g     = 0;
    for (int k = 0; k < P; k++) begin
      int idx;
      idx = (rr + k) % P;
      if (!found && in_valid[idx]) begin
        found = 1;
        g     = idx;
      end
    end
    can = !ov || mo_ready;
    rd  = found && in_re[g];
    acc = found && can && (!rd || q.size() < MO);

    obs_grant = -1;
    for (int p = 0; p < P; p++) if (in_ready[p]) obs_grant = p;
    obs_mo_valid = mo_valid;
    obs_mo_addr  = mo_addr;
    obs_mo_data  = mo_data;
    obs_ri_ready = ri_ready;
    obs_err      = resp_error;
    for (int p = 0; p < P; p++) begin
      obs_ro_valid[p] = ro_valid[p];
      obs_ro_data[p]  = ro_data[p];
    end

    if (!rst) begin
      for (int p = 0; p < P; p++) check("in_ready", in_ready[p], acc && (p == g));
      check("mo_valid", mo_valid, ov);
      if (ov) begin
        check("mo_re", mo_re, ex_re);
        check("mo_we", mo_we, ex_we);
        check("mo_addr", mo_addr, ex_addr);
        check("mo_data", mo_data, ex_data);
        check("mo_id", mo_id, 0);
      end
      for (int p = 0; p < P; p++) begin
        exp_ro = ri_valid && (q.size() > 0) && (q[0] == p);
        check("ro_valid", ro_valid[p], exp_ro);
        if (exp_ro) check("ro_data", ro_data[p], ri_data);
      end
      check("ri_ready", ri_ready, (q.size() == 0) ? 1'b1 : ro_ready[q[0]]);
      check("resp_error", resp_error, err);
    end
    if (mo_valid && mo_ready) hs_count++;

    @(posedge clk);
    if (rst) begin
      rr = 0;
      ov = 0;
      q.delete();
      err = 0;
    end else begin
      pop = ri_valid && (q.size() > 0) && ro_ready[q[0]];
      if (ri_valid && q.size() == 0) err = 1;
      if (pop) void'(q.pop_front());
      if (acc) begin
        ov      = 1;
        ex_re   = in_re[g];
        ex_we   = in_re[g] ? 4'h0 : in_we[g];
        ex_addr = in_addr[g];
        ex_data = in_data[g];
        rr      = (g + 1) % P;
        if (rd) q.push_back(g);
      end else if (ov && mo_ready) begin
        ov = 0;
      end
    end
    #1;
  endtask

  initial begin
    int n;
    rr = 0; ov = 0; err = 0; hs_count = 0;
    ex_re = 0; ex_we = '0; ex_addr = '0; ex_data = '0;
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Two continuous writers alternate, 1 request/cycle, output one cycle behind.
    for (int p = 0; p < P; p++) begin
      in_valid[p] = 1'b1;
      in_addr[p]  = 32'h1000 * (p + 1);
      in_data[p]  = 32'hC0DE0000 + p;
    end
    for (int k = 0; k < 6; k++) begin
      step();
      check("t1_grant", obs_grant, k % 2);
      check("t1_out_valid", obs_mo_valid, k > 0);
    end
    idle();
    step();

    // Read responses routed back in issue order.
    in_valid[1] = 1'b1; in_re[1] = 1'b1; in_addr[1] = 32'h100;
    step();
    check("t2_grant_p1", obs_grant, 1);
    in_valid[1] = 1'b0;
    in_valid[0] = 1'b1; in_re[0] = 1'b1; in_addr[0] = 32'h200;
    step();
    check("t2_grant_p0", obs_grant, 0);
    idle();
    step();
    ri_valid = 1'b1; ri_data = 32'hAAAA;
    step();
    check("t2_p1_valid", obs_ro_valid[1], 1);
    check("t2_p1_data", obs_ro_data[1], 32'hAAAA);
    ri_data = 32'hBBBB;
    step();
    check("t2_p0_valid", obs_ro_valid[0], 1);
    check("t2_p0_data", obs_ro_data[0], 32'hBBBB);
    ri_valid = 1'b0;

    // Outstanding-read limit.
    n = 0;
    in_valid[0] = 1'b1; in_re[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_addr[0] = 32'h300 + 32'(n * 4);
      step();
      if (obs_grant == 0) n++;
    end
    check("t3_accepted", n, 4);
    check("t3_blocked", obs_grant, -1);
    ri_valid = 1'b1; ri_data = 32'h77;
    step();
    check("t3_pop_still_blocked", obs_grant, -1);
    ri_valid = 1'b0;
    step();
    check("t3_fifth_accepted", obs_grant, 0);
    in_valid[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      ri_valid = 1'b1; ri_data = 32'h900 + 32'(c);
      step();
      check("t3_drain_valid", obs_ro_valid[0], 1);
    end
    idle();
    step();

    // Output stall holds the stage and blocks all requesters.
    mo_ready = 1'b0;
    in_valid[0] = 1'b1; in_addr[0] = 32'h40; in_data[0] = 32'h12345678;
    step();
    check("t4_accept", obs_grant, 0);
    in_addr[0] = 32'h44; in_data[0] = 32'h1;
    in_valid[1] = 1'b1; in_addr[1] = 32'h80; in_data[1] = 32'h2;
    for (int c = 0; c < 5; c++) begin
      step();
      check("t4_addr_hold", obs_mo_addr, 32'h40);
      check("t4_data_hold", obs_mo_data, 32'h12345678);
      check("t4_no_grant", obs_grant, -1);
    end
    idle();
    hs_count = 0;
    step(); step(); step();
    check("t4_one_handshake", hs_count, 1);

    // Response with nothing outstanding.
    ri_valid = 1'b1; ri_data = 32'hDEAD;
    step();
    check("t5_no_valid0", obs_ro_valid[0], 0);
    check("t5_no_valid1", obs_ro_valid[1], 0);
    check("t5_consumed", obs_ri_ready, 1);
    ri_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("t5_error_sticky", obs_err, 1);
    end

    // Reset with reads in flight.
    for (int p = 0; p < P; p++) begin
      in_valid[p] = 1'b1; in_re[p] = 1'b1; in_addr[p] = 32'h500 + 32'(p * 256);
    end
    step(); step(); step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("t6_out_valid", obs_mo_valid, 0);
    check("t6_error_clr", obs_err, 0);
    check("t6_fifo_empty", obs_ri_ready, 1);
    for (int p = 0; p < P; p++) begin
      in_valid[p] = 1'b1; in_re[p] = 1'b1; in_addr[p] = 32'h600 + 32'(p);
    end
    step();
    check("t6_rr_zero", obs_grant, 0);
    in_valid[0] = 1'b0;
    in_addr[1]  = 32'h700;
    step();
    check("t6_grant_p1", obs_grant, 1);
    idle();
    step();
    ri_valid = 1'b1; ri_data = 32'h1111;
    step();
    check("t6_resp_p0", obs_ro_valid[0], 1);
    ri_data = 32'h5555;
    step();
    check("t6_resp_p1", obs_ro_valid[1], 1);
    check("t6_resp_p1_data", obs_ro_data[1], 32'h5555);
    ri_valid = 1'b0;
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < P; p++) begin
        in_valid[p] = 1'($urandom_range(0, 1));
        in_re[p]    = ($urandom_range(0, 2) == 0);
        in_we[p]    = 4'($urandom_range(1, 15));
        in_addr[p]  = $urandom;
        in_data[p]  = $urandom;
        ro_ready[p] = ($urandom_range(0, 3) != 0);
      end
      mo_ready = ($urandom_range(0, 3) != 0);
      ri_valid = ($urandom_range(0, 2) == 0);
      ri_data  = $urandom;
      rst      = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
